// File: rtl/wav_pkg.sv
// Shared types and constants for the RIFF/WAVE loader: parser states,
// chunk classification, error codes and little-endian FOURCC words.
package wav_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RIFF_ID,
      S_RIFF_SIZE,
      S_WAVE_ID,
      S_CHUNK_ID,
      S_CHUNK_SIZE,
      S_FMT_BODY,
      S_DATA_BODY,
      S_SKIP_BODY,
      S_PAD,
      S_DONE,
      S_ERROR
   } wav_state_e;

   typedef enum logic [1:0] {
      CK_OTHER,
      CK_FMT,
      CK_DATA
   } chunk_kind_e;

   localparam logic [2:0] ERR_OK        = 3'd0;
   localparam logic [2:0] ERR_BAD_MAGIC = 3'd1;
   localparam logic [2:0] ERR_BAD_FMT   = 3'd2;
   localparam logic [2:0] ERR_ADDR_GAP  = 3'd3;
   localparam logic [2:0] ERR_NO_DATA   = 3'd4;

   // First file byte sits in bits [7:0].
   localparam logic [31:0] FOURCC_RIFF = 32'h4646_4952;
   localparam logic [31:0] FOURCC_WAVE = 32'h4556_4157;
   localparam logic [31:0] FOURCC_FMT  = 32'h2074_6D66;
   localparam logic [31:0] FOURCC_DATA = 32'h6174_6164;

endpackage

// File: rtl/wav_loader_if.sv
// Bundle of the ioctl download port, ROM write port and published status
// of the wave loader; master is the download host side.
interface wav_loader_if #(
   parameter int unsigned ROM_AW = 16
);
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              rom_wr;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              busy;
   logic              wav_valid;
   logic [31:0]       wav_rate;
   logic [15:0]       wav_chans;
   logic [15:0]       wav_bits;
   logic [ROM_AW:0]   wav_len;
   logic              wav_trunc;
   logic [2:0]        wav_err;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  rom_wr, rom_addr, rom_data, busy, wav_valid, wav_rate,
             wav_chans, wav_bits, wav_len, wav_trunc, wav_err
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output rom_wr, rom_addr, rom_data, busy, wav_valid, wav_rate,
             wav_chans, wav_bits, wav_len, wav_trunc, wav_err
   );
endinterface

// File: rtl/wav_le_accum.sv
// Little-endian byte accumulator: assembles 2- or 4-byte fields one byte at
// a time; value includes the current byte so the last byte is usable at once.
module wav_le_accum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  byte_in,
   input  logic [2:0]  nbytes,
   output logic [31:0] value,
   output logic        done
);
   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      value = word_q;
      if (en) value[{idx_q, 3'b000} +: 8] = byte_in;
   end

   assign done = en && ({1'b0, idx_q} == nbytes - 3'd1);

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clr || done) begin
         word_d = '0;
         idx_d  = '0;
      end else if (en) begin
         word_d = value;
         idx_d  = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end
endmodule

// File: rtl/wav_loader.sv
// Streaming RIFF/WAVE parser: validates headers, skips unknown chunks and
// writes PCM payload (16-bit reduced to unsigned 8-bit) into the sample ROM.
module wav_loader
   import wav_pkg::*;
#(
   parameter int unsigned ROM_AW  = 16,
   parameter logic [7:0]  WAV_IDX = 8'd1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              rom_wr,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [7:0]        rom_data,
   output logic              busy,
   output logic              wav_valid,
   output logic [31:0]       wav_rate,
   output logic [15:0]       wav_chans,
   output logic [15:0]       wav_bits,
   output logic [ROM_AW:0]   wav_len,
   output logic              wav_trunc,
   output logic [2:0]        wav_err
);
   wav_state_e        state_q, state_d, body_end;
   chunk_kind_e       kind_q, kind_d;
   logic              dl_q;
   logic [24:0]       exp_addr_q, exp_addr_d;
   logic [31:0]       rem_q, rem_d, rate_q, rate_d;
   logic              odd_q, odd_d, fmt_seen_q, fmt_seen_d, data_done_q, data_done_d;
   logic              hi_q, hi_d, trunc_q, trunc_d, valid_q, valid_d, rom_wr_q, rom_wr_d;
   logic [4:0]        off_q, off_d;
   logic [15:0]       chans_q, chans_d, bits_q, bits_d;
   logic [ROM_AW:0]   len_q, len_d;
   logic [2:0]        err_q, err_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]        rom_data_q, rom_data_d;
   logic              rise, fall, accept, byte_ok, hdr_state, last;
   logic              acc_en, acc_clr, acc_done;
   logic [2:0]        acc_nbytes;
   logic [31:0]       acc_value;

   assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
   assign rise      = ioctl_download && !dl_q && (ioctl_index == WAV_IDX);
   assign fall      = !ioctl_download && dl_q && busy;
   assign accept    = ioctl_wr && busy && !rise && !fall;
   assign byte_ok   = accept && (ioctl_addr == exp_addr_q) && !data_done_q;
   assign hdr_state = state_q inside {S_RIFF_ID, S_RIFF_SIZE, S_WAVE_ID, S_CHUNK_ID, S_CHUNK_SIZE};
   // fmt fields: 2,2,4,4,2,2 bytes; off_q saturates at 16 so trailing bytes bypass the accumulator.
   assign acc_en     = byte_ok && (hdr_state || (state_q == S_FMT_BODY && !off_q[4]));
   assign acc_nbytes = (state_q == S_FMT_BODY && !(off_q[3:2] inside {2'd1, 2'd2})) ? 3'd2 : 3'd4;
   assign acc_clr    = rise || (state_d != state_q);

   wav_le_accum u_accum (
      .clk     (clk_sys),
      .rst     (reset),
      .clr     (acc_clr),
      .en      (acc_en),
      .byte_in (ioctl_dout),
      .nbytes  (acc_nbytes),
      .value   (acc_value),
      .done    (acc_done)
   );

   always_comb begin
      state_d = state_q;  exp_addr_d = exp_addr_q;  rem_d = rem_q;  odd_d = odd_q;
      kind_d = kind_q;  off_d = off_q;  fmt_seen_d = fmt_seen_q;  data_done_d = data_done_q;
      hi_d = hi_q;  rate_d = rate_q;  chans_d = chans_q;  bits_d = bits_q;  len_d = len_q;
      trunc_d = trunc_q;  valid_d = valid_q;  err_d = err_q;
      rom_wr_d = 1'b0;  rom_addr_d = rom_addr_q;  rom_data_d = rom_data_q;
      last     = (rem_q == 32'd1);
      body_end = odd_q ? S_PAD : S_CHUNK_ID;

      if (rise) begin
         state_d = S_RIFF_ID;  valid_d = 1'b0;  err_d = ERR_OK;  trunc_d = 1'b0;
         len_d = '0;  exp_addr_d = '0;  fmt_seen_d = 1'b0;  data_done_d = 1'b0;
      end else if (fall) begin
         if (state_q == S_DATA_BODY || data_done_q) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            if (rem_q != '0) trunc_d = 1'b1;
         end else begin
            state_d = S_ERROR;
            err_d   = ERR_NO_DATA;
         end
      end else if (accept && ioctl_addr != exp_addr_q) begin
         state_d = S_ERROR;
         err_d   = ERR_ADDR_GAP;
      end else if (accept) begin
         exp_addr_d = exp_addr_q + 25'd1;
         if (!data_done_q) begin
            case (state_q)
               S_RIFF_ID: if (acc_done) begin
                  state_d = (acc_value == FOURCC_RIFF) ? S_RIFF_SIZE : S_ERROR;
                  if (acc_value != FOURCC_RIFF) err_d = ERR_BAD_MAGIC;
               end
               S_RIFF_SIZE: if (acc_done) state_d = S_WAVE_ID;
               S_WAVE_ID: if (acc_done) begin
                  state_d = (acc_value == FOURCC_WAVE) ? S_CHUNK_ID : S_ERROR;
                  if (acc_value != FOURCC_WAVE) err_d = ERR_BAD_MAGIC;
               end
               S_CHUNK_ID: if (acc_done) begin
                  state_d = S_CHUNK_SIZE;
                  kind_d  = (acc_value == FOURCC_FMT)  ? CK_FMT :
                            (acc_value == FOURCC_DATA) ? CK_DATA : CK_OTHER;
               end
               S_CHUNK_SIZE: if (acc_done) begin
                  rem_d = acc_value;  odd_d = acc_value[0];  off_d = '0;  hi_d = 1'b0;
                  case (kind_q)
                     CK_FMT: begin
                        state_d = (acc_value == '0) ? S_ERROR : S_FMT_BODY;
                        if (acc_value == '0) err_d = ERR_BAD_FMT;
                     end
                     CK_DATA: begin
                        if (!fmt_seen_q) begin
                           state_d = S_ERROR;
                           err_d   = ERR_NO_DATA;
                        end else if (acc_value == '0) begin
                           state_d     = S_CHUNK_ID;
                           data_done_d = 1'b1;
                        end else begin
                           state_d = S_DATA_BODY;
                        end
                     end
                     default: state_d = (acc_value == '0) ? S_CHUNK_ID : S_SKIP_BODY;
                  endcase
               end
               S_FMT_BODY: begin
                  rem_d = rem_q - 32'd1;
                  if (!off_q[4]) off_d = off_q + 5'd1;
                  if (acc_done) begin
                     case (off_q)
                        5'd1: if (acc_value[15:0] != 16'd1) begin
                           state_d = S_ERROR;
                           err_d   = ERR_BAD_FMT;
                        end
                        5'd3: chans_d = acc_value[15:0];
                        5'd7: rate_d  = acc_value;
                        5'd15: begin
                           if (acc_value[15:0] == 16'd8 || acc_value[15:0] == 16'd16) begin
                              bits_d     = acc_value[15:0];
                              fmt_seen_d = 1'b1;
                           end else begin
                              state_d = S_ERROR;
                              err_d   = ERR_BAD_FMT;
                           end
                        end
                        default: ;
                     endcase
                  end
                  // A fmt chunk that ends before the bits field is malformed.
                  if (last && state_d == S_FMT_BODY) begin
                     state_d = fmt_seen_d ? body_end : S_ERROR;
                     if (!fmt_seen_d) err_d = ERR_BAD_FMT;
                  end
               end
               S_DATA_BODY: begin
                  rem_d = rem_q - 32'd1;
                  hi_d  = !hi_q;
                  if (bits_q != 16'd16 || hi_q) begin
                     if (len_q[ROM_AW]) begin
                        trunc_d = 1'b1;
                     end else begin
                        rom_wr_d   = 1'b1;
                        rom_addr_d = len_q[ROM_AW-1:0];
                        rom_data_d = (bits_q == 16'd16) ? (ioctl_dout ^ 8'h80) : ioctl_dout;
                        len_d      = len_q + 1'b1;
                     end
                  end
                  if (last) begin
                     state_d     = S_CHUNK_ID;
                     data_done_d = 1'b1;
                  end
               end
               S_SKIP_BODY: begin
                  rem_d = rem_q - 32'd1;
                  if (last) state_d = body_end;
               end
               S_PAD: state_d = S_CHUNK_ID;
               default: ;
            endcase
         end
      end
   end

   // Edge detector follows the pin through reset so a reset mid-download sees no new start.
   always_ff @(posedge clk_sys) dl_q <= ioctl_download;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= S_IDLE;  kind_q <= CK_OTHER;  exp_addr_q <= '0;  rem_q <= '0;
         odd_q <= 1'b0;  off_q <= '0;  fmt_seen_q <= 1'b0;  data_done_q <= 1'b0;
         hi_q <= 1'b0;  rate_q <= '0;  chans_q <= '0;  bits_q <= '0;  len_q <= '0;
         trunc_q <= 1'b0;  valid_q <= 1'b0;  err_q <= ERR_OK;
         rom_wr_q <= 1'b0;  rom_addr_q <= '0;  rom_data_q <= '0;
      end else begin
         state_q <= state_d;  kind_q <= kind_d;  exp_addr_q <= exp_addr_d;  rem_q <= rem_d;
         odd_q <= odd_d;  off_q <= off_d;  fmt_seen_q <= fmt_seen_d;  data_done_q <= data_done_d;
         hi_q <= hi_d;  rate_q <= rate_d;  chans_q <= chans_d;  bits_q <= bits_d;  len_q <= len_d;
         trunc_q <= trunc_d;  valid_q <= valid_d;  err_q <= err_d;
         rom_wr_q <= rom_wr_d;  rom_addr_q <= rom_addr_d;  rom_data_q <= rom_data_d;
      end
   end

   assign rom_wr    = rom_wr_q;
   assign rom_addr  = rom_addr_q;
   assign rom_data  = rom_data_q;
   assign wav_valid = valid_q;
   assign wav_rate  = rate_q;
   assign wav_chans = chans_q;
   assign wav_bits  = bits_q;
   assign wav_len   = len_q;
   assign wav_trunc = trunc_q;
   assign wav_err   = err_q;
endmodule

// File: tb/tb_wav_loader.sv
// Scoreboard bench for wav_loader: files are built byte by byte, expected ROM
// writes are queued as stimulus is built and popped by per-DUT write monitors.
module tb_wav_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wav_loader_if #(.ROM_AW(16)) bus0 ();
   wav_loader_if #(.ROM_AW(4))  bus1 ();

   assign bus1.ioctl_download = bus0.ioctl_download;
   assign bus1.ioctl_index    = bus0.ioctl_index;
   assign bus1.ioctl_wr       = bus0.ioctl_wr;
   assign bus1.ioctl_addr     = bus0.ioctl_addr;
   assign bus1.ioctl_dout     = bus0.ioctl_dout;

   wav_loader #(.ROM_AW(16), .WAV_IDX(8'd1)) dut0 (
      .clk_sys(clk), .reset(rst),
      .ioctl_download(bus0.ioctl_download), .ioctl_index(bus0.ioctl_index),
      .ioctl_wr(bus0.ioctl_wr), .ioctl_addr(bus0.ioctl_addr), .ioctl_dout(bus0.ioctl_dout),
      .rom_wr(bus0.rom_wr), .rom_addr(bus0.rom_addr), .rom_data(bus0.rom_data),
      .busy(bus0.busy), .wav_valid(bus0.wav_valid), .wav_rate(bus0.wav_rate),
      .wav_chans(bus0.wav_chans), .wav_bits(bus0.wav_bits), .wav_len(bus0.wav_len),
      .wav_trunc(bus0.wav_trunc), .wav_err(bus0.wav_err)
   );

   wav_loader #(.ROM_AW(4), .WAV_IDX(8'd2)) dut1 (
      .clk_sys(clk), .reset(rst),
      .ioctl_download(bus1.ioctl_download), .ioctl_index(bus1.ioctl_index),
      .ioctl_wr(bus1.ioctl_wr), .ioctl_addr(bus1.ioctl_addr), .ioctl_dout(bus1.ioctl_dout),
      .rom_wr(bus1.rom_wr), .rom_addr(bus1.rom_addr), .rom_data(bus1.rom_data),
      .busy(bus1.busy), .wav_valid(bus1.wav_valid), .wav_rate(bus1.wav_rate),
      .wav_chans(bus1.wav_chans), .wav_bits(bus1.wav_bits), .wav_len(bus1.wav_len),
      .wav_trunc(bus1.wav_trunc), .wav_err(bus1.wav_err)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [23:0] q0[$];
   logic [23:0] q1[$];
   logic [7:0]  file[$];

   always @(negedge clk) begin : mon0
      logic [23:0] e;
      if (bus0.rom_wr) begin
         vectors++;
         if (q0.size() == 0) begin
            miscompares++;
            $display("FAIL rom0_write actual=%0h:%0h required=no write", bus0.rom_addr, bus0.rom_data);
         end else begin
            e = q0.pop_front();
            if ({bus0.rom_addr, bus0.rom_data} !== e) begin
               miscompares++;
               $display("FAIL rom0_write actual=%0h:%0h required=%0h:%0h",
                        bus0.rom_addr, bus0.rom_data, e[23:8], e[7:0]);
            end
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [23:0] e;
      if (bus1.rom_wr) begin
         vectors++;
         if (q1.size() == 0) begin
            miscompares++;
            $display("FAIL rom1_write actual=%0h:%0h required=no write", bus1.rom_addr, bus1.rom_data);
         end else begin
            e = q1.pop_front();
            if ({12'h000, bus1.rom_addr, bus1.rom_data} !== e) begin
               miscompares++;
               $display("FAIL rom1_write actual=%0h:%0h required=%0h:%0h",
                        bus1.rom_addr, bus1.rom_data, e[23:8], e[7:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic put8(input logic [7:0] b);
      file.push_back(b);
   endtask

   task automatic put16(input int unsigned v);
      for (int k = 0; k < 2; k++) put8(v[8*k +: 8]);
   endtask

   task automatic put32(input int unsigned v);
      for (int k = 0; k < 4; k++) put8(v[8*k +: 8]);
   endtask

   task automatic putstr(input string s);
      for (int k = 0; k < 4; k++) put8(s[k]);
   endtask

   task automatic hdr(input string magic, input int unsigned chans, input int unsigned rate,
                      input int unsigned bits, input int unsigned fmt);
      file.delete();
      putstr(magic); put32(36); putstr("WAVE");
      putstr("fmt "); put32(16);
      put16(fmt); put16(chans); put32(rate);
      put32(rate * chans * bits / 8); put16(chans * bits / 8); put16(bits);
   endtask

   // Data chunk of n bytes (value 8'h11*(k+1)); 8-bit files expect a ROM write per byte.
   task automatic data8(input int n, input int n_expected);
      putstr("data"); put32(n);
      for (int k = 0; k < n; k++) begin
         put8(8'(8'h11 * (k + 1)));
         if (k < n_expected) q0.push_back({16'(k), 8'(8'h11 * (k + 1))});
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  32'(bus0.busy), 0);
      check({tag, "_valid"}, 32'(bus0.wav_valid), 0);
      check({tag, "_err"},   32'(bus0.wav_err), 0);
      check({tag, "_len"},   32'(bus0.wav_len), 0);
      check({tag, "_hdr"},   {bus0.wav_chans, bus0.wav_bits} | bus0.wav_rate, 0);
      check({tag, "_rom"},   {7'd0, bus0.rom_wr, bus0.rom_addr, bus0.rom_data, 1'b0, bus0.wav_trunc}, 0);
   endtask

   task automatic status0(input string tag, input int err, input int valid, input int trunc, input int len);
      check({tag, "_err"},   32'(bus0.wav_err), 32'(err));
      check({tag, "_valid"}, 32'(bus0.wav_valid), 32'(valid));
      check({tag, "_trunc"}, 32'(bus0.wav_trunc), 32'(trunc));
      check({tag, "_len"},   32'(bus0.wav_len), 32'(len));
      check({tag, "_busy"},  32'(bus0.busy), 0);
      check({tag, "_pending"}, 32'(q0.size()), 0);
   endtask

   task automatic run_file(input logic [7:0] idx, input int skip_at, input int reset_at);
      @(posedge clk); #1;
      bus0.ioctl_index    = idx;
      bus0.ioctl_download = 1'b1;
      for (int i = 0; i < file.size(); i++) begin
         @(posedge clk); #1;
         rst               = (i == reset_at);
         bus0.ioctl_wr     = 1'b1;
         bus0.ioctl_dout   = file[i];
         bus0.ioctl_addr   = (skip_at >= 0 && i >= skip_at) ? 25'(i + 1) : 25'(i);
         if (reset_at >= 0 && i == reset_at + 1) begin
            @(negedge clk);
            check_zero("midreset");
         end
      end
      @(posedge clk); #1;
      rst                 = 1'b0;
      bus0.ioctl_wr       = 1'b0;
      bus0.ioctl_download = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus0.ioctl_download = 1'b0;
      bus0.ioctl_index    = 8'd0;
      bus0.ioctl_wr       = 1'b0;
      bus0.ioctl_addr     = '0;
      bus0.ioctl_dout     = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // 8-bit mono 8000 Hz, five payload bytes
      hdr("RIFF", 1, 8000, 8, 1);
      data8(5, 5);
      run_file(8'd1, -1, -1);
      status0("t1", 0, 1, 0, 5);
      check("t1_rate",  bus0.wav_rate, 32'd8000);
      check("t1_chans", 32'(bus0.wav_chans), 32'd1);
      check("t1_bits",  32'(bus0.wav_bits), 32'd8);

      // 16-bit: 8000,7FFF,0000 -> 00,FF,80
      hdr("RIFF", 1, 44100, 16, 1);
      putstr("data"); put32(6);
      put8(8'h00); put8(8'h80); put8(8'hFF); put8(8'h7F); put8(8'h00); put8(8'h00);
      q0.push_back({16'd0, 8'h00}); q0.push_back({16'd1, 8'hFF}); q0.push_back({16'd2, 8'h80});
      run_file(8'd1, -1, -1);
      status0("t2", 0, 1, 0, 3);
      check("t2_bits", 32'(bus0.wav_bits), 32'd16);
      check("t2_rate", bus0.wav_rate, 32'd44100);

      // odd-sized LIST chunk with pad byte ahead of data
      hdr("RIFF", 2, 22050, 8, 1);
      putstr("LIST"); put32(3); put8(8'hDE); put8(8'hAD); put8(8'hBE); put8(8'h00);
      data8(4, 4);
      run_file(8'd1, -1, -1);
      status0("t3", 0, 1, 0, 4);
      check("t3_chans", 32'(bus0.wav_chans), 32'd2);

      // bad magic
      hdr("RIFX", 1, 8000, 8, 1);
      data8(5, 0);
      run_file(8'd1, -1, -1);
      status0("t4a", 1, 0, 0, 0);

      // non-PCM audio format
      hdr("RIFF", 1, 8000, 8, 3);
      data8(5, 0);
      run_file(8'd1, -1, -1);
      status0("t4b", 2, 0, 0, 0);

      // 16-byte ROM fed 20 bytes; the index-1 loader must ignore this download
      hdr("RIFF", 1, 8000, 8, 1);
      putstr("data"); put32(20);
      for (int k = 0; k < 20; k++) begin
         put8(8'(k * 7 + 3));
         if (k < 16) q1.push_back({16'(k), 8'(k * 7 + 3)});
      end
      run_file(8'd2, -1, -1);
      check("t5_len",     32'(bus1.wav_len), 32'd16);
      check("t5_trunc",   32'(bus1.wav_trunc), 32'd1);
      check("t5_valid",   32'(bus1.wav_valid), 32'd1);
      check("t5_err",     32'(bus1.wav_err), 32'd0);
      check("t5_pending", 32'(q1.size()), 0);
      check("t5_other_err", 32'(bus0.wav_err), 32'd2);

      // address gap 10 -> 12
      hdr("RIFF", 1, 8000, 8, 1);
      data8(5, 0);
      run_file(8'd1, 11, -1);
      status0("t6a", 3, 0, 0, 0);

      // reset while the fourth payload byte is presented (header is 44 bytes)
      hdr("RIFF", 1, 8000, 8, 1);
      data8(8, 3);
      run_file(8'd1, -1, 47);
      status0("t6b", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/wav_loader.md
# wav_loader

Streaming RIFF/WAVE parser between the `hps_io` ioctl download port and the wave-sample ROM (`dpram_dc`) read by the wave sound player.

- Consumes the downloaded `.wav` byte stream and validates the RIFF/WAVE/`fmt ` headers.
- Skips unknown chunks.
- Writes only PCM payload bytes to the ROM from address 0, converting 16-bit samples to the player's unsigned 8-bit format.
- Publishes sample rate, channel count, bit depth, stored length and a status code, so the player trigger logic knows what and how much to play.

## Interface
Parameters:
- `ROM_AW`, 16: ROM address width; capacity 2^ROM_AW bytes.
- `WAV_IDX`, 8'd1: `ioctl_index` value that selects this loader.

Ports:
- `clk_sys`  in  1  system clock; everything is on this clock.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  download window from `hps_io`.
- `ioctl_index`  in  8  download target index.
- `ioctl_wr`  in  1  byte strobe, one cycle per byte.
- `ioctl_addr`  in  25  byte offset in the file.
- `ioctl_dout`  in  8  byte value.
- `rom_wr`  out  1  ROM write enable.
- `rom_addr`  out  ROM_AW  ROM write address.
- `rom_data`  out  8  ROM write data.
- `busy`  out  1  high while parsing a selected download.
- `wav_valid`  out  1  level; high once a file has parsed successfully; cleared at the next selected download start.
- `wav_rate`  out  32  sample rate in Hz.
- `wav_chans`  out  16  channel count.
- `wav_bits`  out  16  bits per sample (8 or 16).
- `wav_len`  out  ROM_AW+1  number of bytes stored in the ROM.
- `wav_trunc`  out  1  payload exceeded ROM capacity, or the data chunk ended early.
- `wav_err`  out  3  error code: 0 OK, 1 BAD_MAGIC, 2 BAD_FMT, 3 ADDR_GAP, 4 NO_DATA.

## Operation
**Start of download.** A rising edge of `ioctl_download` with `ioctl_index==WAV_IDX` does all of the following:
- Enters state RIFF_ID and sets `busy`.
- Clears `wav_valid`, `wav_err`, `wav_trunc`, `wav_len`, the expected address counter, and the fmt_seen flag.
- Any other index is ignored; the block stays in its current state.

**Byte acceptance.** Each `ioctl_wr` while `busy`:
- If `ioctl_addr` differs from the expected address: go to ERROR with code 3.
- Otherwise the expected address increments.

**Parser states.** Multi-byte fields are little-endian and accumulate over 2 or 4 bytes.
- IDLE.
- RIFF_ID: must read "RIFF", else error 1.
- RIFF_SIZE: 4 bytes, ignored.
- WAVE_ID: must read "WAVE", else error 1.
- CHUNK_ID.
- CHUNK_SIZE: latches a 32-bit remaining count.
- FMT_BODY:
  - fields are audio_format, channels, rate, byte_rate, block_align, bits;
  - audio_format≠1 or bits∉{8,16} → error 2;
  - bytes beyond 16 are skipped;
  - sets fmt_seen.
- DATA_BODY: entered only if fmt_seen, else error 4.
- SKIP_BODY: any other chunk ID.
- PAD: consumes one pad byte after an odd-sized chunk.
- DONE.
- ERROR.

**Transitions.**
- A body with remaining count 0 returns to CHUNK_ID, or to PAD first if the chunk size is odd.
- A zero-size chunk goes straight from CHUNK_SIZE to CHUNK_ID/PAD.
- After the data chunk completes, further bytes are ignored (DONE is entered at download end).

**DATA_BODY storage.**
- 8-bit samples: every byte is written as-is.
- 16-bit samples: only the odd (high) byte of each sample is written, as `byte^8'h80`; the low byte is dropped.
- Writes stop when `wav_len==2^ROM_AW`; the rest is discarded and `wav_trunc` is set.

**End of download** (falling edge of `ioctl_download` while `busy`):
- In DATA_BODY or after data completed → DONE, `wav_valid`=1. `wav_trunc` is also set if remaining≠0.
- Any other state → ERROR with code 4.
- `busy` drops in both cases.

**ERROR** is sticky until the next selected download start or `reset`; no further ROM writes occur in ERROR.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- `reset` wins over a simultaneous `ioctl_wr` or download edge.
- Reset mid-download aborts parsing; remaining bytes of that download are ignored because no rising edge is seen.
- `rom_wr`/`rom_addr`/`rom_data` are registered, one cycle after the accepted `ioctl_wr`.
- `wav_len` updates on the same cycle as `rom_wr`.
- Back-to-back `ioctl_wr` on every cycle is supported.
- Status outputs (`wav_valid`, `wav_err`, `busy`) update one cycle after the `ioctl_download` falling edge or the offending byte.
- Header fields update the cycle after their last byte and are held until the next selected download start.

## Structure
- Package `wav_pkg`:
  - parser state enum;
  - error code localparams;
  - FOURCC constants "RIFF", "WAVE", "fmt ", "data" as 32-bit little-endian words.
- Sub-module `wav_le_accum`: byte-shift accumulator assembling up to 32 bits little-endian, with byte-index counter, clear and done outputs. It is reused for field and ID capture.

## Test plan
1. Minimal 8-bit mono 8000 Hz file, data size 5 → five `rom_wr` at addresses 0..4 with the exact bytes; `wav_rate`=8000, `wav_chans`=1, `wav_bits`=8, `wav_len`=5, `wav_valid`=1, `wav_err`=0.
2. 16-bit file with samples 16'h8000, 16'h7FFF, 16'h0000 → ROM bytes 8'h00, 8'hFF, 8'h80; `wav_len`=3.
3. A "LIST" chunk of size 3 (odd, plus pad byte) placed before "data" → the LIST chunk is skipped, the first payload byte lands at ROM address 0, and no writes occur during LIST.
4. Header "RIFX" → `wav_err`=1 after byte 3 and no `rom_wr`. Separately, audio_format=3 → `wav_err`=2.
5. ROM_AW=4 with a data size of 20 → 16 writes, `wav_len`=16, `wav_trunc`=1, `wav_valid`=1.
6. `ioctl_addr` skips from 10 to 12 → `wav_err`=3. Separately, `reset` asserted mid-DATA_BODY → all outputs 0 on the next cycle and no further writes.
